mem_port_arbiter: RTL and testbench

- Shares one single-ported instruction/data memory bus between the IF stage (fetch) and the MEM stage (load/store driven by the EXE-to-MEM pipeline register outputs).
- Sequences multi-cycle bus transactions with a req/ack handshake and generates the freeze signals that hold the pipeline registers while an access is outstanding.
- MEM has priority over IF; a one-entry fetch buffer preserves a fetch that completes while the front end is frozen.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_fetch_buffer.sv | 39 +++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned WordLenDefault = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMemBusy = 2'd1,
        StIfBusy  = 2'd2,
        StIfDrop  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_fetch_buffer.sv
// One-entry fetch buffer: holds a fetch that completed while the front end was frozen.
module mem_port_arbiter_fetch_buffer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LEN = WordLenDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capture,
    input  logic [WORD_LEN-1:0] capture_addr,
    input  logic [WORD_LEN-1:0] capture_data,
    input  logic                invalidate,
    input  logic [WORD_LEN-1:0] lookup_addr,
    output logic                hit,
    output logic [WORD_LEN-1:0] rdata
);

    logic                valid_q;
    logic [WORD_LEN-1:0] addr_q;
    logic [WORD_LEN-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (capture) begin
            valid_q <= 1'b1;
            addr_q  <= capture_addr;
            data_q  <= capture_data;
        end else if (invalidate) begin
            valid_q <= 1'b0;
        end
    end

    assign hit   = valid_q && (addr_q == lookup_addr);
    assign rdata = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus between fetch (IF) and load/store (MEM), MEM first,
// and generates the pipeline freeze signals while an access is outstanding.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LEN = WordLenDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [WORD_LEN-1:0] if_addr,
    input  logic                if_flush,
    output logic [WORD_LEN-1:0] if_rdata,
    output logic                if_ready,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [WORD_LEN-1:0] mem_addr,
    input  logic [WORD_LEN-1:0] mem_wdata,
    output logic [WORD_LEN-1:0] mem_rdata,
    output logic                mem_ready,
    output logic                freeze_mem,
    output logic                freeze_if,
    output logic                bus_req,
    output logic                bus_we,
    output logic [WORD_LEN-1:0] bus_addr,
    output logic [WORD_LEN-1:0] bus_wdata,
    input  logic [WORD_LEN-1:0] bus_rdata,
    input  logic                bus_ack
);

    arb_state_e          state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [WORD_LEN-1:0] bus_addr_q, bus_addr_d;
    logic [WORD_LEN-1:0] bus_wdata_q, bus_wdata_d;

    logic                mem_req;
    logic                ack_mem;
    logic                ack_if;
    logic                buf_hit;
    logic                buf_take;
    logic                buf_capture;
    logic                buf_invalidate;
    logic [WORD_LEN-1:0] buf_rdata;

    mem_port_arbiter_fetch_buffer #(
        .WORD_LEN(WORD_LEN)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst          (rst),
        .capture      (buf_capture),
        .capture_addr (bus_addr_q),
        .capture_data (bus_rdata),
        .invalidate   (buf_invalidate),
        .lookup_addr  (if_addr),
        .hit          (buf_hit),
        .rdata        (buf_rdata)
    );

    always_comb begin
        mem_req    = mem_r_en | mem_w_en;
        ack_mem    = (state_q == StMemBusy) && bus_ack;
        // A flush coinciding with the fetch ack makes that data stale as well.
        ack_if     = (state_q == StIfBusy) && bus_ack && !if_flush;
        freeze_mem = mem_req && !ack_mem;
        buf_take   = if_req && buf_hit && !freeze_mem && !if_flush && !ack_if;
        if_ready   = (ack_if && !freeze_mem) || buf_take;
        if_rdata   = ack_if ? bus_rdata : buf_rdata;
        freeze_if  = freeze_mem || (if_req && !if_ready);
        mem_ready  = ack_mem;
        mem_rdata  = bus_rdata;

        buf_capture    = ack_if && freeze_mem;
        // Entry dies when consumed, flushed, or the front end moves on to another address.
        buf_invalidate = if_flush || buf_take || (!freeze_if && !buf_hit);
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    state_d     = StMemBusy;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_w_en;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                end else if (if_req && !buf_hit && !if_flush) begin
                    state_d    = StIfBusy;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = if_addr;
                end
            end
            StMemBusy, StIfDrop: begin
                if (bus_ack) begin
                    state_d   = StIdle;
                    bus_req_d = 1'b0;
                end
            end
            StIfBusy: begin
                if (bus_ack) begin
                    state_d   = StIdle;
                    bus_req_d = 1'b0;
                end else if (if_flush) begin
                    state_d = StIfDrop;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the bench plays the memory side.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_r_en, mem_w_en, bus_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ready, mem_ready, freeze_mem, freeze_if, bus_req, bus_we;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.WORD_LEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .freeze_mem (freeze_mem),
        .freeze_if  (freeze_if),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 0; if_flush = 0; mem_r_en = 0; mem_w_en = 0; bus_ack = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; bus_rdata = 0;
        step(); step();
        n_vec++;
        if ({bus_req, bus_we, bus_addr, bus_wdata} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h, want all 0",
                     bus_req, bus_we, bus_addr, bus_wdata);
        end
        rst = 1'b1; mem_r_en = 1'b1; mem_addr = 32'h44;
        step();
        n_vec++;
        if (bus_req !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_grant: bus_req=%b want 1", bus_req);
        end
        rst = 1'b0; mem_r_en = 1'b0;
        step(); step();
        n_vec++;
        if (bus_req !== 1'b0 || freeze_mem !== 1'b0 || bus_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_txn: req=%b freeze_mem=%b addr=%h want 0 0 0",
                     bus_req, freeze_mem, bus_addr);
        end
        rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h0BAD0BAD;
        #1;
        n_vec++;
        if (mem_ready !== 1'b0 || if_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stray_ack: mem_ready=%b if_ready=%b want 0 0", mem_ready, if_ready);
        end
        step();
        bus_ack = 1'b0;
        n_vec++;
        if (bus_req !== 1'b0) begin
            n_err++; $display("FAIL reset_stray_ack_req: bus_req=%b want 0", bus_req);
        end
    endtask

    task automatic test_load();
        int freeze_cnt = 0;
        int ready_cnt  = 0;
        mem_r_en = 1'b1; mem_addr = 32'h40; bus_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            bus_ack = (i == 4);
            #1;
            if (freeze_mem === 1'b1) freeze_cnt++;
            if (mem_ready === 1'b1) ready_cnt++;
            if (i == 1) begin
                n_vec++;
                if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h40) begin
                    n_err++;
                    $display("FAIL load_grant: req=%b we=%b addr=%h want 1 0 00000040",
                             bus_req, bus_we, bus_addr);
                end
            end
            if (i == 4) begin
                n_vec++;
                if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEADBEEF) begin
                    n_err++;
                    $display("FAIL load_ack: mem_ready=%b mem_rdata=%h want 1 deadbeef",
                             mem_ready, mem_rdata);
                end
            end
            step();
        end
        mem_r_en = 1'b0; bus_ack = 1'b0;
        n_vec++;
        if (freeze_cnt != 4 || ready_cnt != 1) begin
            n_err++;
            $display("FAIL load_counts: freeze cycles=%0d ready pulses=%0d want 4 1",
                     freeze_cnt, ready_cnt);
        end
        n_vec++;
        if (bus_req !== 1'b0) begin
            n_err++; $display("FAIL load_release: bus_req=%b want 0", bus_req);
        end
    endtask

    task automatic test_store();
        int ready_cnt = 0;
        int bad_hold  = 0;
        mem_w_en = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            bus_ack = (i == 3);
            #1;
            if (mem_ready === 1'b1) ready_cnt++;
            if (i >= 1 && (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h80 ||
                           bus_wdata !== 32'h12345678)) bad_hold++;
            step();
        end
        mem_w_en = 1'b0; bus_ack = 1'b0;
        n_vec++;
        if (bad_hold != 0 || ready_cnt != 1) begin
            n_err++;
            $display("FAIL store_hold: unstable cycles=%0d ready pulses=%0d want 0 1",
                     bad_hold, ready_cnt);
        end
        // Both enables at once is a write.
        mem_r_en = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h84; mem_wdata = 32'h0000CAFE;
        step();
        n_vec++;
        if (bus_we !== 1'b1 || bus_addr !== 32'h84 || bus_wdata !== 32'h0000CAFE) begin
            n_err++;
            $display("FAIL store_both_en: we=%b addr=%h wdata=%h want 1 00000084 0000cafe",
                     bus_we, bus_addr, bus_wdata);
        end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 32'h100; mem_r_en = 1'b1; mem_addr = 32'h200;
        step();
        n_vec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h200 || bus_we !== 1'b0) begin
            n_err++;
            $display("FAIL contend_mem_first: req=%b addr=%h we=%b want 1 00000200 0",
                     bus_req, bus_addr, bus_we);
        end
        bus_ack = 1'b1; bus_rdata = 32'h33333333;
        #1;
        n_vec++;
        if (mem_ready !== 1'b1 || freeze_mem !== 1'b0 || freeze_if !== 1'b1) begin
            n_err++;
            $display("FAIL contend_mem_ack: mem_ready=%b freeze_mem=%b freeze_if=%b want 1 0 1",
                     mem_ready, freeze_mem, freeze_if);
        end
        step();
        bus_ack = 1'b0; mem_r_en = 1'b0;
        n_vec++;
        if (bus_req !== 1'b0) begin
            n_err++; $display("FAIL contend_turnaround: bus_req=%b want 0", bus_req);
        end
        step();
        n_vec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0) begin
            n_err++;
            $display("FAIL contend_if_grant: req=%b addr=%h we=%b want 1 00000100 0",
                     bus_req, bus_addr, bus_we);
        end
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        #1;
        n_vec++;
        if (if_ready !== 1'b1 || if_rdata !== 32'hCAFEF00D || freeze_if !== 1'b0) begin
            n_err++;
            $display("FAIL contend_if_ack: if_ready=%b if_rdata=%h freeze_if=%b want 1 cafef00d 0",
                     if_ready, if_rdata, freeze_if);
        end
        step();
        bus_ack = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_fetch_buffer();
        if_req = 1'b1; if_addr = 32'h10;
        step();
        n_vec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h10) begin
            n_err++; $display("FAIL fbuf_if_grant: req=%b addr=%h want 1 00000010", bus_req, bus_addr);
        end
        mem_r_en = 1'b1; mem_addr = 32'h300; bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
        #1;
        n_vec++;
        if (if_ready !== 1'b0 || freeze_mem !== 1'b1 || freeze_if !== 1'b1) begin
            n_err++;
            $display("FAIL fbuf_frozen_ack: if_ready=%b freeze_mem=%b freeze_if=%b want 0 1 1",
                     if_ready, freeze_mem, freeze_if);
        end
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        n_vec++;
        if (if_ready !== 1'b0) begin
            n_err++; $display("FAIL fbuf_idle_frozen: if_ready=%b want 0", if_ready);
        end
        step();
        n_vec++;
        if (bus_addr !== 32'h300 || bus_req !== 1'b1) begin
            n_err++; $display("FAIL fbuf_mem_grant: req=%b addr=%h want 1 00000300", bus_req, bus_addr);
        end
        step();
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        #1;
        n_vec++;
        if (mem_ready !== 1'b1 || if_ready !== 1'b1 || if_rdata !== 32'hA5A5A5A5 ||
            freeze_if !== 1'b0) begin
            n_err++;
            $display("FAIL fbuf_release: mem_ready=%b if_ready=%b if_rdata=%h freeze_if=%b want 1 1 a5a5a5a5 0",
                     mem_ready, if_ready, if_rdata, freeze_if);
        end
        step();
        bus_ack = 1'b0; mem_r_en = 1'b0; if_addr = 32'h14;
        #1;
        n_vec++;
        if (if_ready !== 1'b0 || bus_req !== 1'b0) begin
            n_err++;
            $display("FAIL fbuf_consumed: if_ready=%b bus_req=%b want 0 0", if_ready, bus_req);
        end
        step();
        n_vec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h14) begin
            n_err++; $display("FAIL fbuf_next_fetch: req=%b addr=%h want 1 00000014", bus_req, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 32'h22222222;
        #1;
        n_vec++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h22222222) begin
            n_err++;
            $display("FAIL fbuf_next_data: if_ready=%b if_rdata=%h want 1 22222222", if_ready, if_rdata);
        end
        step();
        bus_ack = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_flush();
        // Flush while idle: no grant, no ready.
        if_req = 1'b1; if_addr = 32'h20; if_flush = 1'b1;
        #1;
        n_vec++;
        if (if_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_idle_ready: if_ready=%b want 0", if_ready);
        end
        step();
        n_vec++;
        if (bus_req !== 1'b0) begin
            n_err++; $display("FAIL flush_idle_grant: bus_req=%b want 0", bus_req);
        end
        if_flush = 1'b0;
        step();
        n_vec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h20) begin
            n_err++; $display("FAIL flush_fetch_grant: req=%b addr=%h want 1 00000020", bus_req, bus_addr);
        end
        if_flush = 1'b1; if_addr = 32'h80;
        step();
        if_flush = 1'b0;
        n_vec++;
        if (bus_req !== 1'b1 || if_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_drop_wait: bus_req=%b if_ready=%b want 1 0", bus_req, if_ready);
        end
        bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
        #1;
        n_vec++;
        if (if_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_discard: if_ready=%b want 0", if_ready);
        end
        step();
        bus_ack = 1'b0;
        step();
        n_vec++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h80) begin
            n_err++; $display("FAIL flush_refetch: req=%b addr=%h want 1 00000080", bus_req, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 32'h600D600D;
        #1;
        n_vec++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h600D600D) begin
            n_err++;
            $display("FAIL flush_new_data: if_ready=%b if_rdata=%h want 1 600d600d", if_ready, if_rdata);
        end
        step();
        bus_ack = 1'b0; if_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_contention();
        test_fetch_buffer();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
